// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver control path: FSM state
// encoding, frame width and the oversampling ratios the receiver supports.
package uart_rx_pkg;

    localparam int DATA_W = 8;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Behaviour is only defined for these oversampling ratios.
    function automatic bit prescale_is_legal(input int p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and data-bit index for the UART receiver.
// edge_cnt runs 0..P-1 within a bit and wraps; bit_cnt advances on the
// wrap when the FSM asks for it.
module edge_bit_counter
#(
    parameter int PRESCALE_W = 6
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_clr,
    input  logic                  bit_clr,
    input  logic                  bit_inc,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  edge_last
);

    logic [PRESCALE_W-1:0] edge_cnt_reg;
    logic [3:0]            bit_cnt_reg;

    assign edge_last = (edge_cnt_reg == (prescale - PRESCALE_W'(1)));
    assign edge_cnt  = edge_cnt_reg;
    assign bit_cnt   = bit_cnt_reg;

    // Edge position inside the current bit; cleared while idle or leaving to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_reg <= '0;
        end else if (cnt_clr || edge_last) begin
            edge_cnt_reg <= '0;
        end else begin
            edge_cnt_reg <= edge_cnt_reg + PRESCALE_W'(1);
        end
    end

    // Data-bit index, stepped at the end of each data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_reg <= 4'd0;
        end else if (bit_clr) begin
            bit_cnt_reg <= 4'd0;
        end else if (bit_inc && edge_last) begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM. Waits for the start bit, walks through
// start / data / [parity] / stop bits with one-cycle enables at the
// mid-bit sample point, and reports each frame as a one-cycle
// data_valid or frame_err.
// Build option: define UART_RX_PARITY_EN to include the PARITY state and
// the sticky parity error; otherwise par_en and par_err are ignored and
// par_chk_en is constant 0.
module uart_rx_fsm
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = uart_rx_pkg::DATA_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  deser_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  data_valid,
    output logic                  frame_err
);

    import uart_rx_pkg::*;

    rx_state_t state_reg;
    rx_state_t state_next;

    logic                  edge_last;
    logic [PRESCALE_W-1:0] premid_pt;
    logic [PRESCALE_W-1:0] eval_pt;
    logic                  at_premid;
    logic                  at_eval;
    logic                  bit_last;
    logic                  frame_bad;
    logic                  res_evt;
    logic                  data_valid_reg;
    logic                  frame_err_reg;

    // MID = P/2 + 2 is where the sampled bit is ready; strobes are registered,
    // so they are launched one edge earlier. EVAL = MID + 1 is when the
    // checker flag answering that strobe is valid.
    assign premid_pt = (prescale >> 1) + PRESCALE_W'(1);
    assign eval_pt   = (prescale >> 1) + PRESCALE_W'(3);
    assign at_premid = (edge_cnt == premid_pt);
    assign at_eval   = (edge_cnt == eval_pt);
    assign bit_last  = (bit_cnt == 4'(DATA_W - 1));

    edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .cnt_clr   ((state_reg == ST_IDLE) || (state_next == ST_IDLE)),
        .bit_clr   (state_reg != ST_DATA),
        .bit_inc   ((state_reg == ST_DATA) && !bit_last),
        .prescale  (prescale),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .edge_last (edge_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; STOP leaves at EVAL so a back-to-back start bit is seen.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!rx_in) state_next = ST_START;
            end
            ST_START: begin
                if (at_eval && strt_glitch) state_next = ST_IDLE;
                else if (edge_last)         state_next = ST_DATA;
            end
            ST_DATA: begin
                if (edge_last && bit_last) begin
`ifdef UART_RX_PARITY_EN
                    state_next = par_en ? ST_PARITY : ST_STOP;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (edge_last) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (at_eval) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dat_samp_en = (state_reg != ST_IDLE);

    // One registered mid-bit strobe per always-present bit type:
    // 0 = start checker, 1 = deserializer, 2 = stop checker.
    for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
        localparam rx_state_t OWN_STATE = rx_state_t'((gi == 0) ? ST_START :
                                                      ((gi == 1) ? ST_DATA : ST_STOP));
        logic strobe_reg;

        // Fire for exactly the cycle in which edge_cnt equals MID.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                strobe_reg <= 1'b0;
            end else begin
                strobe_reg <= (state_reg == OWN_STATE) && at_premid;
            end
        end
    end

    assign strt_chk_en = g_strobe[0].strobe_reg;
    assign deser_en    = g_strobe[1].strobe_reg;
    assign stp_chk_en  = g_strobe[2].strobe_reg;

`ifdef UART_RX_PARITY_EN
    logic par_strobe_reg;
    logic sticky_err_reg;

    // Parity checker strobe at MID of the parity bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_strobe_reg <= 1'b0;
        end else begin
            par_strobe_reg <= (state_reg == ST_PARITY) && at_premid;
        end
    end

    // Parity error held until the next start bit so the stop decision can use it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_err_reg <= 1'b0;
        end else if ((state_reg == ST_IDLE) && (state_next == ST_START)) begin
            sticky_err_reg <= 1'b0;
        end else if ((state_reg == ST_PARITY) && at_eval) begin
            sticky_err_reg <= sticky_err_reg | par_err;
        end
    end

    assign par_chk_en = par_strobe_reg;
    assign frame_bad  = stp_err | sticky_err_reg;
`else
    logic unused_parity_inputs;

    assign unused_parity_inputs = par_en ^ par_err;
    assign par_chk_en           = 1'b0;
    assign frame_bad            = stp_err;
`endif

    assign res_evt = (state_reg == ST_STOP) && at_eval;

    // Frame outcome, registered from the stop checker's EVAL cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            data_valid_reg <= res_evt && !frame_bad;
            frame_err_reg  <= res_evt && frame_bad;
        end
    end

    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule
